shift_sequencer: RTL and testbench

Multi-cycle shift controller for the ALU16 datapath. It implements shift-by-N (N = 0..15) by applying a single-bit shift step N times, one step per clock. It covers logical left, logical right, arithmetic right and rotate left, with a START/BUSY/DONE handshake. It sits beside ALU16 and is driven by the main control unit for shift-class instructions, so the datapath never needs a barrel shifter.

---
 rtl/shift_defs.sv | 24 ++
 rtl/shift_step.sv | 29 ++
 rtl/shift_sequencer.sv | 100 ++++++++++
 tb/tb_shift_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/shift_defs.sv
// shift_defs
// Shared encodings for the shift sequencer and the main control unit.
//   shift_op_t : operation codes (SLL/SRL/SRA/ROL), same values the control
//                unit places on the shift-class OP field.
//   state_t    : shift sequencer FSM states.
package shift_defs;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AMT_W = 4;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// shift_step
// Combinational single-bit shift step. The SLL case is the plain
// left-by-one shifter; the other cases reuse the same one-bit slice.
// Ports:
//   d  in  WIDTH  value to step
//   op in  2      operation (shift_op_t)
//   q  out WIDTH  stepped value (shifted-out bit is dropped)
module shift_step
    import shift_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  shift_op_t        op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer
// Multi-cycle shift controller beside ALU16: shift-by-N is done as N
// single-bit steps, one per clock, with a start/busy/done handshake.
// Ports:
//   clk      in  1      system clock, rising edge
//   reset    in  1      synchronous, active-high reset
//   start    in  1      shift request, sampled only in ST_IDLE
//   op       in  2      00 SLL, 01 SRL, 10 SRA, 11 ROL
//   amount   in  AMT_W  shift count (unsigned)
//   data_in  in  WIDTH  operand, captured when start is accepted
//   result   out WIDTH  working register; holds until the next acceptance
//   busy     out 1      high from acceptance until done drops
//   done     out 1      one-cycle pulse, result valid in the same cycle
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for start; acceptance also does the amount==0 check
// ST_SHIFT  | one step per edge, count down to zero
// ST_FINISH | shifting complete; raises the registered done/busy pulse
module shift_sequencer
    import shift_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    state_t           state;
    shift_op_t        op_q;
    logic [AMT_W-1:0] count;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_step;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d  (work),
        .op (op_q),
        .q  (work_step)
    );

    // done/busy are registered, so the done pulse appears the cycle after
    // ST_FINISH, while the FSM is already back in ST_IDLE. The working
    // register is untouched there, so result stays valid alongside done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            op_q  <= OP_SLL;
            count <= '0;
            work  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        work  <= data_in;
                        op_q  <= shift_op_t'(op);
                        count <= amount;
                        busy  <= 1'b1;
                        state <= (amount == '0) ? ST_FINISH : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work  <= work_step;
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign result = work;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  amount;
    logic [15:0] data_in;
    logic [15:0] result;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    shift_sequencer #(
        .WIDTH (16),
        .AMT_W (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .amount  (amount),
        .data_in (data_in),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one shift, then track latency, result and busy width.
    // Accepted at edge k: done expected after edge k+N+1, busy for N+2 cycles.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [3:0] a,
                          input logic [15:0] d, input logic [15:0] exp);
        int edges;
        int busy_cyc;
        bit seen;
        start   = 1'b1;
        op      = o;
        amount  = a;
        data_in = d;
        tick();
        start   = 1'b0;
        op      = 2'($urandom);
        amount  = 4'($urandom);
        data_in = 16'($urandom);
        edges    = 0;
        busy_cyc = 0;
        seen     = 1'b0;
        while (edges <= 40) begin
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
            edges++;
        end
        check({nm, ".done_seen"}, 32'(seen), 32'd1);
        check({nm, ".latency"}, 32'(edges), 32'(a) + 32'd1);
        check({nm, ".result"}, 32'(result), 32'(exp));
        tick();
        if (!busy) busy_cyc = busy_cyc;
        check({nm, ".done_fall"}, 32'(done), 32'd0);
        check({nm, ".busy_cycles"}, 32'(busy_cyc), 32'(a) + 32'd2);
        check({nm, ".busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        n_checks = 0;
        n_fail   = 0;

        //           op     amt     din       exp
        vecs[0]  = '{2'b00, 4'd1,  16'd100,  16'd200};
        vecs[1]  = '{2'b00, 4'd1,  16'hFFFF, 16'hFFFE};
        vecs[2]  = '{2'b10, 4'd15, 16'h8000, 16'hFFFF};
        vecs[3]  = '{2'b01, 4'd15, 16'h8000, 16'h0001};
        vecs[4]  = '{2'b00, 4'd0,  16'h1234, 16'h1234};
        vecs[5]  = '{2'b01, 4'd0,  16'h1234, 16'h1234};
        vecs[6]  = '{2'b10, 4'd0,  16'h1234, 16'h1234};
        vecs[7]  = '{2'b11, 4'd0,  16'h1234, 16'h1234};
        vecs[8]  = '{2'b11, 4'd4,  16'h8001, 16'h0018};
        vecs[9]  = '{2'b10, 4'd3,  16'h8421, 16'hF084};
        vecs[10] = '{2'b01, 4'd4,  16'h8421, 16'h0842};
        vecs[11] = '{2'b11, 4'd15, 16'h1234, 16'h091A};
        vecs[12] = '{2'b00, 4'd15, 16'h0001, 16'h8000};
        vecs[13] = '{2'b10, 4'd4,  16'h7FF0, 16'h07FF};
        vecs[14] = '{2'b11, 4'd1,  16'hC000, 16'h8001};

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        amount  = 4'd0;
        data_in = 16'h0;
        repeat (3) tick();
        check("reset.result", 32'(result), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].din, vecs[i].exp);
        end

        // start during shift must be ignored: SLL 1 by 3, intrusion 0xFFFF.
        start = 1'b1; op = 2'b00; amount = 4'd3; data_in = 16'h0001;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; op = 2'b01; amount = 4'd0; data_in = 16'hFFFF;
        tick();
        start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                done_cnt++;
                check("intrude.result", 32'(result), 32'h0008);
            end
            tick();
        end
        check("intrude.done_pulses", 32'(done_cnt), 32'd1);
        check("intrude.busy_end", 32'(busy), 32'd0);

        // reset in cycle 5 of SLL-by-10 discards the shift with no done.
        start = 1'b1; op = 2'b00; amount = 4'd10; data_in = 16'h0001;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("midreset.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset.result", 32'(result), 32'd0);
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.done", 32'(done), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        check("midreset.no_done", 32'(done_cnt), 32'd0);
        run_op("after_reset", 2'b01, 4'd4, 16'h0010, 16'h0001);

        // reset and start on the same edge: reset wins.
        reset = 1'b1; start = 1'b1; op = 2'b00; amount = 4'd2; data_in = 16'hABCD;
        tick();
        reset = 1'b0; start = 1'b0;
        check("rst_start.busy", 32'(busy), 32'd0);
        check("rst_start.result", 32'(result), 32'd0);
        tick();
        check("rst_start.busy_later", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

endmodule
